// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM state encoding, letter codes A-H and the
// dot/dash pattern table used by both the transmit and receive stages.
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MARK  = 3'd1,
    ST_SPACE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [2:0] LTR_A = 3'd0;
  localparam logic [2:0] LTR_B = 3'd1;
  localparam logic [2:0] LTR_C = 3'd2;
  localparam logic [2:0] LTR_D = 3'd3;
  localparam logic [2:0] LTR_E = 3'd4;
  localparam logic [2:0] LTR_F = 3'd5;
  localparam logic [2:0] LTR_G = 3'd6;
  localparam logic [2:0] LTR_H = 3'd7;

  // Mark run length at which a mark is always rejected.
  localparam logic [2:0] RUN_SAT = 3'd4;

  // bits: LSB = last symbol sent, dot = 0, dash = 1, unused upper bits 0.
  typedef struct packed {
    logic [2:0] letter;
    logic [2:0] len;
    logic [3:0] bits;
  } pattern_t;

  localparam int unsigned NUM_LETTERS = 8;

  localparam pattern_t PATTERN_TABLE [NUM_LETTERS] = '{
    '{letter: LTR_A, len: 3'd2, bits: 4'b0001},
    '{letter: LTR_B, len: 3'd4, bits: 4'b1000},
    '{letter: LTR_C, len: 3'd4, bits: 4'b1010},
    '{letter: LTR_D, len: 3'd3, bits: 4'b0100},
    '{letter: LTR_E, len: 3'd1, bits: 4'b0000},
    '{letter: LTR_F, len: 3'd4, bits: 4'b0010},
    '{letter: LTR_G, len: 3'd3, bits: 4'b0110},
    '{letter: LTR_H, len: 3'd4, bits: 4'b0000}
  };

endpackage

// File: rtl/morse_pattern_lookup.sv
// Combinational pattern matcher: (sym_len, sym_bits) -> (hit, letter).
module morse_pattern_lookup
  import morse_pkg::*;
#(
  parameter int unsigned MAX_SYMBOLS = 4,
  parameter int unsigned LEN_W       = 3
) (
  input  logic [LEN_W-1:0]       sym_len,
  input  logic [MAX_SYMBOLS-1:0] sym_bits,
  output logic                   hit,
  output logic [2:0]             letter
);

  // Scan the table; patterns are unique so at most one entry matches.
  always_comb begin
    hit    = 1'b0;
    letter = '0;
    for (int unsigned i = 0; i < NUM_LETTERS; i++) begin
      if ((32'(sym_len) == 32'(PATTERN_TABLE[i].len)) &&
          (32'(sym_bits) == 32'(PATTERN_TABLE[i].bits))) begin
        hit    = 1'b1;
        letter = PATTERN_TABLE[i].letter;
      end
    end
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse receive stage: measures mark/space run lengths on `light`, rebuilds
// the dot/dash pattern and maps it back to a 3-bit letter code A-H.
// Optional macro MORSE_DECODER_TOLERANT_EN: marks of 2 or 3 samples are dashes.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int unsigned GAP_TICKS   = 3,
  parameter int unsigned MAX_SYMBOLS = 4
) (
  input  logic       half_sec,
  input  logic       reset,
  input  logic       light,
  output logic [2:0] letter_out,
  output logic       letter_valid,
  output logic       code_error,
  output logic [2:0] sym_count,
  output logic [2:0] state
);

  localparam int unsigned LEN_W = $clog2(MAX_SYMBOLS + 1);

  state_t                 state_q, state_d;
  logic [2:0]             run_cnt_q, run_cnt_d;
  logic [1:0]             off_cnt_q, off_cnt_d;
  logic [MAX_SYMBOLS-1:0] sym_bits_q, sym_bits_d;
  logic [LEN_W-1:0]       sym_len_q, sym_len_d;
  logic [2:0]             letter_q, letter_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic                   is_dot, is_dash;
  logic                   lk_hit;
  logic [2:0]             lk_letter;

  morse_pattern_lookup #(
    .MAX_SYMBOLS (MAX_SYMBOLS),
    .LEN_W       (LEN_W)
  ) u_lookup (
    .sym_len  (sym_len_q),
    .sym_bits (sym_bits_q),
    .hit      (lk_hit),
    .letter   (lk_letter)
  );

  // Classify the just-finished mark by its run length.
  always_comb begin
    is_dot = (run_cnt_q == 3'd1);
`ifdef MORSE_DECODER_TOLERANT_EN
    is_dash = (run_cnt_q == 3'd2) || (run_cnt_q == 3'd3);
`else
    is_dash = (run_cnt_q == 3'd3);
`endif
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge half_sec) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      run_cnt_q  <= '0;
      off_cnt_q  <= '0;
      sym_bits_q <= '0;
      sym_len_q  <= '0;
      letter_q   <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      off_cnt_q  <= off_cnt_d;
      sym_bits_q <= sym_bits_d;
      sym_len_q  <= sym_len_d;
      letter_q   <= letter_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // Next-state and counter/pattern updates.
  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    off_cnt_d  = off_cnt_q;
    sym_bits_d = sym_bits_q;
    sym_len_d  = sym_len_q;
    unique case (state_q)
      ST_IDLE: begin
        sym_len_d  = '0;
        sym_bits_d = '0;
        if (light) begin
          state_d   = ST_MARK;
          run_cnt_d = 3'd1;
        end
      end
      ST_MARK: begin
        if (light) begin
          run_cnt_d = (run_cnt_q == RUN_SAT) ? RUN_SAT : run_cnt_q + 3'd1;
          if (run_cnt_d == RUN_SAT) begin
            state_d   = ST_ERR;
            off_cnt_d = '0;
          end
        end else if (!(is_dot || is_dash) || (sym_len_q == LEN_W'(MAX_SYMBOLS))) begin
          // The rejecting 0 sample already counts toward the quiet wait.
          state_d   = ST_ERR;
          off_cnt_d = 2'd1;
        end else begin
          state_d    = ST_SPACE;
          off_cnt_d  = 2'd1;
          sym_bits_d = (sym_bits_q << 1) | MAX_SYMBOLS'(is_dash);
          sym_len_d  = sym_len_q + LEN_W'(1);
        end
      end
      ST_SPACE: begin
        if (light) begin
          state_d   = ST_MARK;
          run_cnt_d = 3'd1;
        end else if (off_cnt_q == 2'(GAP_TICKS - 1)) begin
          state_d = ST_DONE;
        end else begin
          off_cnt_d = off_cnt_q + 2'd1;
        end
      end
      ST_DONE: begin
        sym_len_d  = '0;
        sym_bits_d = '0;
        if (light) begin
          state_d   = ST_MARK;
          run_cnt_d = 3'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (light) begin
          off_cnt_d = '0;
        end else if (off_cnt_q == 2'(GAP_TICKS - 1)) begin
          state_d    = ST_IDLE;
          sym_len_d  = '0;
          sym_bits_d = '0;
        end else begin
          off_cnt_d = off_cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered result pulses, decided on the edge that enters DONE or ERR.
  always_comb begin
    valid_d  = (state_q == ST_SPACE) && (state_d == ST_DONE) && lk_hit;
    err_d    = ((state_q == ST_SPACE) && (state_d == ST_DONE) && !lk_hit) ||
               ((state_q == ST_MARK) && (state_d == ST_ERR));
    letter_d = valid_d ? lk_letter : letter_q;
  end

  assign letter_out   = letter_q;
  assign letter_valid = valid_q;
  assign code_error   = err_q;
  assign sym_count    = 3'(sym_len_q);
  assign state        = state_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed self-checking bench for morse_decoder (GAP_TICKS=3, MAX_SYMBOLS=4).
module tb_morse_decoder;

  logic       half_sec = 1'b0;
  logic       reset    = 1'b0;
  logic       light    = 1'b0;
  logic [2:0] letter_out;
  logic       letter_valid;
  logic       code_error;
  logic [2:0] sym_count;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  morse_decoder #(
    .GAP_TICKS   (3),
    .MAX_SYMBOLS (4)
  ) dut (
    .half_sec     (half_sec),
    .reset        (reset),
    .light        (light),
    .letter_out   (letter_out),
    .letter_valid (letter_valid),
    .code_error   (code_error),
    .sym_count    (sym_count),
    .state        (state)
  );

  always #5 half_sec = ~half_sec;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step(input logic l);
    light = l;
    @(posedge half_sec);
    #1;
    if (letter_valid === 1'b1) vld_cnt++;
    if (code_error === 1'b1) err_cnt++;
    if (letter_valid === 1'b1 && code_error === 1'b1) both_cnt++;
  endtask

  task automatic clr_counts();
    vld_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(1'b0);
    step(1'b1);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (letter_out !== 3'd0) begin errors++; $display("FAIL rst_letter got=%0d exp=0", letter_out); end
    checks++; if (letter_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", letter_valid); end
    checks++; if (code_error !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", code_error); end
    checks++; if (sym_count !== 3'd0) begin errors++; $display("FAIL rst_symcnt got=%0d exp=0", sym_count); end
    reset = 1'b1;
    step(1'b0);
  endtask

  task automatic test_letter_a();
    clr_counts();
    step(1); step(0); step(1); step(1); step(1); step(0); step(0);
    checks++; if (sym_count !== 3'd2) begin errors++; $display("FAIL a_symcnt got=%0d exp=2", sym_count); end
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL a_space got=%0d exp=2", state); end
    step(0);
    checks++; if (letter_valid !== 1'b1) begin errors++; $display("FAIL a_valid got=%b exp=1", letter_valid); end
    checks++; if (letter_out !== 3'd0) begin errors++; $display("FAIL a_letter got=%0d exp=0", letter_out); end
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL a_done got=%0d exp=3", state); end
    step(0);
    checks++; if (state !== 3'd0 || sym_count !== 3'd0) begin errors++; $display("FAIL a_idle got state=%0d symcnt=%0d exp 0/0", state, sym_count); end
    checks++; if (vld_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL a_pulses got vld=%0d err=%0d exp 1/0", vld_cnt, err_cnt); end
  endtask

  task automatic test_letter_d();
    clr_counts();
    step(1); step(1); step(1); step(0); step(1); step(0); step(1); step(0); step(0);
    checks++; if (sym_count !== 3'd3) begin errors++; $display("FAIL d_symcnt got=%0d exp=3", sym_count); end
    step(0);
    checks++; if (letter_valid !== 1'b1 || letter_out !== 3'd3) begin errors++; $display("FAIL d_decode got valid=%b letter=%0d exp 1/3", letter_valid, letter_out); end
    step(0);
    checks++; if (vld_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL d_pulses got vld=%0d err=%0d exp 1/0", vld_cnt, err_cnt); end
  endtask

  task automatic test_back_to_back();
    clr_counts();
    step(1); step(0); step(1); step(0); step(1); step(0); step(1); step(0); step(0);
    checks++; if (sym_count !== 3'd4) begin errors++; $display("FAIL h_symcnt got=%0d exp=4", sym_count); end
    step(0);
    checks++; if (letter_valid !== 1'b1 || letter_out !== 3'd7) begin errors++; $display("FAIL h_decode got valid=%b letter=%0d exp 1/7", letter_valid, letter_out); end
    step(1);
    checks++; if (state !== 3'd1 || sym_count !== 3'd0) begin errors++; $display("FAIL b2b_mark got state=%0d symcnt=%0d exp 1/0", state, sym_count); end
    checks++; if (letter_out !== 3'd7 || letter_valid !== 1'b0) begin errors++; $display("FAIL b2b_hold got letter=%0d valid=%b exp 7/0", letter_out, letter_valid); end
    step(0); step(0); step(0);
    checks++; if (letter_valid !== 1'b1 || letter_out !== 3'd4) begin errors++; $display("FAIL e_decode got valid=%b letter=%0d exp 1/4", letter_valid, letter_out); end
    step(0);
    checks++; if (vld_cnt != 2 || err_cnt != 0) begin errors++; $display("FAIL b2b_pulses got vld=%0d err=%0d exp 2/0", vld_cnt, err_cnt); end
  endtask

  task automatic test_short_mark();
    clr_counts();
    step(1); step(1); step(0);
`ifdef MORSE_DECODER_TOLERANT_EN
    checks++; if (state !== 3'd2 || code_error !== 1'b0) begin errors++; $display("FAIL short_class got state=%0d err=%b exp 2/0", state, code_error); end
`else
    checks++; if (state !== 3'd4 || code_error !== 1'b1) begin errors++; $display("FAIL short_class got state=%0d err=%b exp 4/1", state, code_error); end
`endif
    step(0); step(0);
`ifdef MORSE_DECODER_TOLERANT_EN
    checks++; if (state !== 3'd3 || code_error !== 1'b1) begin errors++; $display("FAIL short_end got state=%0d err=%b exp 3/1", state, code_error); end
`else
    checks++; if (state !== 3'd0 || code_error !== 1'b0) begin errors++; $display("FAIL short_end got state=%0d err=%b exp 0/0", state, code_error); end
`endif
    step(0);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL short_idle got=%0d exp=0", state); end
    checks++; if (err_cnt != 1 || vld_cnt != 0 || letter_out !== 3'd4) begin errors++; $display("FAIL short_pulses got err=%0d vld=%0d letter=%0d exp 1/0/4", err_cnt, vld_cnt, letter_out); end
  endtask

  task automatic test_g_prefix();
    clr_counts();
    step(1); step(1); step(1); step(0); step(1); step(1); step(1); step(0); step(0);
    checks++; if (sym_count !== 3'd2) begin errors++; $display("FAIL g_symcnt got=%0d exp=2", sym_count); end
    step(0);
    checks++; if (code_error !== 1'b1 || letter_valid !== 1'b0 || state !== 3'd3) begin errors++; $display("FAIL g_done got err=%b valid=%b state=%0d exp 1/0/3", code_error, letter_valid, state); end
    checks++; if (letter_out !== 3'd4) begin errors++; $display("FAIL g_hold got=%0d exp=4", letter_out); end
    step(0);
    checks++; if (state !== 3'd0 || err_cnt != 1) begin errors++; $display("FAIL g_idle got state=%0d err=%0d exp 0/1", state, err_cnt); end
  endtask

  task automatic test_long_mark();
    clr_counts();
    step(1); step(1); step(1);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL long_mark got=%0d exp=1", state); end
    step(1);
    checks++; if (state !== 3'd4 || code_error !== 1'b1) begin errors++; $display("FAIL long_err got state=%0d err=%b exp 4/1", state, code_error); end
    step(0); step(0);
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL long_wait got=%0d exp=4", state); end
    step(0);
    checks++; if (state !== 3'd0 || err_cnt != 1 || vld_cnt != 0) begin errors++; $display("FAIL long_idle got state=%0d err=%0d vld=%0d exp 0/1/0", state, err_cnt, vld_cnt); end
  endtask

  task automatic test_five_dots();
    clr_counts();
    step(1); step(0); step(1); step(0); step(1); step(0); step(1); step(0);
    step(1);
    checks++; if (state !== 3'd1 || sym_count !== 3'd4) begin errors++; $display("FAIL five_mark got state=%0d symcnt=%0d exp 1/4", state, sym_count); end
    step(0);
    checks++; if (state !== 3'd4 || code_error !== 1'b1) begin errors++; $display("FAIL five_err got state=%0d err=%b exp 4/1", state, code_error); end
    step(0); step(1); step(0); step(0);
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL five_restart got=%0d exp=4", state); end
    step(0);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL five_idle got=%0d exp=0", state); end
    checks++; if (err_cnt != 1 || vld_cnt != 0) begin errors++; $display("FAIL five_pulses got err=%0d vld=%0d exp 1/0", err_cnt, vld_cnt); end
  endtask

  task automatic test_reset_mid();
    clr_counts();
    step(1); step(1); step(1); step(0);
    checks++; if (state !== 3'd2 || sym_count !== 3'd1) begin errors++; $display("FAIL mid_pre got state=%0d symcnt=%0d exp 2/1", state, sym_count); end
    reset = 1'b0;
    step(0);
    reset = 1'b1;
    checks++; if (state !== 3'd0 || sym_count !== 3'd0) begin errors++; $display("FAIL mid_state got state=%0d symcnt=%0d exp 0/0", state, sym_count); end
    checks++; if (letter_out !== 3'd0 || letter_valid !== 1'b0 || code_error !== 1'b0) begin errors++; $display("FAIL mid_outs got letter=%0d valid=%b err=%b exp 0/0/0", letter_out, letter_valid, code_error); end
    step(1); step(0); step(1); step(1); step(1); step(0); step(0); step(0);
    checks++; if (letter_valid !== 1'b1 || letter_out !== 3'd0) begin errors++; $display("FAIL mid_a got valid=%b letter=%0d exp 1/0", letter_valid, letter_out); end
    step(0);
    checks++; if (err_cnt != 0 || vld_cnt != 1) begin errors++; $display("FAIL mid_pulses got err=%0d vld=%0d exp 0/1", err_cnt, vld_cnt); end
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_letter_d();
    test_back_to_back();
    test_short_mark();
    test_g_prefix();
    test_long_mark();
    test_five_dots();
    test_reset_mid();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL exclusive got=%0d exp=0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Receive-side stage for the Morse transmitter. It samples the transmitter's `light` output once per `half_sec` clock, measures mark and space run lengths, and rebuilds the dot/dash pattern. It then maps the pattern back to the 3-bit letter code (A–H) used on the transmit side. Together the two stages form a loopback for checking the encoder, length counter, shift register and FSM path end to end.

## Interface
- `GAP_TICKS`, default 3: consecutive off samples that end a letter; minimum 2.
- `MAX_SYMBOLS`, default 4: longest accepted pattern.
- `half_sec` in 1: the single clock; `light` is sampled on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `light` in 1: serial Morse input (1 = mark).
- `letter_out` out 3: decoded letter (000 = A … 111 = H); holds its value until the next valid decode.
- `letter_valid` out 1: one-cycle pulse when `letter_out` is updated.
- `code_error` out 1: one-cycle pulse on a bad mark length, an overlong pattern or an unmatched pattern.
- `sym_count` out 3: symbols collected so far in the current letter.
- `state` out 3: current FSM state code, for debug LEDs.

## Operation
- Internal registers:
  - `run_cnt`: 3 bits, saturating at 4.
  - `off_cnt`: 2 bits.
  - `sym_bits`: `MAX_SYMBOLS` bits; shifts left, LSB = newest symbol; dot = 0, dash = 1.
  - `sym_len`.
- FSM states: IDLE = 0, MARK = 1, SPACE = 2, DONE = 3, ERR = 4.
- **IDLE:**
  - `light` = 1: go to MARK; `run_cnt` = 1, `sym_len` = 0, `sym_bits` = 0.
  - Otherwise stay in IDLE.
- **MARK:**
  - `light` = 1: increment `run_cnt`. If the count would reach 4, go to ERR.
  - `light` = 0: classify the mark. `run_cnt` 1 = dot, 3 = dash, anything else goes to ERR.
  - If `sym_len` == `MAX_SYMBOLS`, go to ERR.
  - Otherwise append the symbol and go to SPACE with `off_cnt` = 1.
- **SPACE:**
  - `light` = 1: go to MARK with `run_cnt` = 1.
  - `light` = 0 and `off_cnt` == `GAP_TICKS`−1: go to DONE.
  - Otherwise increment `off_cnt`.
- **DONE** (exactly one cycle): look up (`sym_len`, `sym_bits`).
  - Match: register `letter_out` and pulse `letter_valid`.
  - No match: pulse `code_error`.
  - Next state: MARK (`run_cnt` = 1, pattern cleared) if `light` = 1 this cycle, else IDLE.
- **ERR:**
  - `code_error` pulses on entry only.
  - Wait for `GAP_TICKS` consecutive 0 samples; any 1 restarts the wait. Then go to IDLE.
  - No `letter_valid` is produced for the discarded letter.
- Pattern table (len:bits):
  - A 2:01, B 4:1000, C 4:1010, D 3:100
  - E 1:0, F 4:0010, G 3:110, H 4:0000
- `sym_count` mirrors `sym_len`. It clears in IDLE and on entry to MARK from DONE.

## Timing
- Reset (`reset` = 0 at an edge):
  - state = IDLE.
  - `letter_out` = 0, `letter_valid` = 0, `code_error` = 0, `sym_count` = 0.
  - All counters = 0.
- Reset mid-letter discards the partial pattern with no error pulse.
- All outputs are registered; there is no combinational path from `light` to any output.
- Latency: last mark sample at edge k; 0s at edges k+1…k+`GAP_TICKS`. DONE is entered at edge k+`GAP_TICKS`, and `letter_valid` is high from that edge until the next.
- Back-to-back letters need at least `GAP_TICKS` off samples between them. A 1 arriving in the DONE cycle is counted as the first mark sample of the next letter.
- `letter_valid` and `code_error` are never high in the same cycle.

## Configuration
- `MORSE_DECODER_TOLERANT_EN`
  - Defined: a mark of 2 or 3 samples is a dash, 1 is a dot, 4 or more goes to ERR.
  - Undefined: only exactly 1 (dot) and exactly 3 (dash) are accepted.
- `GAP_TICKS` handling is identical in both builds.

## Structure
- Package `morse_pkg` holds:
  - letter code constants A–H;
  - the state encoding constants;
  - the pattern table (len/bits per letter), shared with the encoder side.
- Sub-module `morse_pattern_lookup`: combinational; (`sym_len`, `sym_bits`) → (`hit`, `letter`). The FSM and counters stay in `morse_decoder`.

## Test plan
- **A:** after reset, drive 1,0,1,1,1,0,0,0. Expect `letter_valid` for one cycle with `letter_out` = 000 after the third 0 edge; `sym_count` = 2 before DONE.
- **H then E back-to-back:** four dots, three 0s, 1, three 0s. Expect `letter_out` = 111 and then 100, with two `letter_valid` pulses and no `code_error`.
- **Mark of 2 samples, then 3 zeros:**
  - Without the macro: `code_error` pulses once, no `letter_valid`, and the block is back in IDLE after 3 quiet samples.
  - With the macro: decodes as a single-dash pattern (len 1, bits 1). This is unmatched, so `code_error` pulses in DONE.
- **Dash, dash (G prefix only), then gap:** `code_error` pulses in the DONE cycle; `letter_out` keeps its previous value.
- **Five dots:** ERR entered on the fifth mark's falling sample with one `code_error` pulse. Marks arriving during the wait restart it; no decode until 3 quiet samples.
- **Reset mid-letter:** hold `reset` = 0 for one edge after the first dash of C. Expect all outputs 0 and state 0; a following A decodes to 000 normally.
